direct_cache_ctrl: RTL
======================

# direct_cache_ctrl

Controller for the direct-mapped cache: accepts single-word CPU read/write requests and performs tag lookup against internal tag/valid/data arrays. Sequences read-miss line fills and write-through transfers to main memory over a req/ack handshake. It sits between the processor's memory port and the main-memory RAM and owns all cache state, including a sequenced flush and saturating hit/miss statistics.

## Interface
- DataWidth, 8, word width of CPU and memory data
- AddrWidth, 16, word address width
- IndexBits, 4, index width; 2^IndexBits lines of one word each; tag = AddrWidth-IndexBits bits
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  request pulse; accepted only in a cycle where cpu_ready=1
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req
- cpu_addr  in  AddrWidth  word address; sampled with cpu_req
- cpu_wdata  in  DataWidth  write data; sampled with cpu_req
- cpu_ready  out  1  high only in IDLE with flush low
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DataWidth  read data; valid while cpu_ack=1, held until next read completes
- mem_req  out  1  memory request, held high until mem_ack
- mem_we  out  1  memory write enable, stable while mem_req=1
- mem_addr  out  AddrWidth  memory address, stable while mem_req=1
- mem_wdata  out  DataWidth  memory write data, stable while mem_req=1
- mem_rdata  in  DataWidth  fill data, sampled in the mem_ack cycle
- mem_ack  in  1  memory completion; ignored unless mem_req=1
- flush  in  1  invalidate all lines; sampled in IDLE only
- flushing  out  1  high during FLUSH
- hit_count  out  16  saturating lookup-hit counter
- miss_count  out  16  saturating lookup-miss counter

## Operation
- Lookup: index = addr[IndexBits-1:0]; tag = addr[AddrWidth-1:IndexBits]; hit = valid[index] and tag_array[index]==tag.
- States: IDLE, LOOKUP, FILL, WRITE, RESP, FLUSH.
- IDLE: flush=1 -> FLUSH, line counter cleared to 0. Otherwise cpu_req=1 -> latch we/addr/wdata into request register -> LOOKUP. flush has priority over cpu_req when both are high; the request is not accepted (cpu_ready=0 in that cycle).
- LOOKUP, read hit: cpu_rdata <= data_array[index] -> RESP.
- LOOKUP, read miss: -> FILL.
- LOOKUP, any write: -> WRITE. Policy is write-through, no write-allocate.
- Each lookup increments exactly one of hit_count or miss_count, writes included. Counters stick at 16'hFFFF.
- FILL: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack:
  - data_array[index] <= mem_rdata; tag_array[index] <= tag; valid[index] <= 1
  - cpu_rdata <= mem_rdata; -> RESP
- WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values. On mem_ack: if the line hit at lookup, data_array[index] <= latched wdata (valid/tag unchanged); a missing line is left untouched -> RESP.
- RESP: cpu_ack=1 -> IDLE.
- FLUSH: valid[counter] <= 0 each cycle, counter increments; at counter = 2^IndexBits-1, clear that line and -> IDLE. Takes exactly 2^IndexBits cycles. Data and tag arrays are not cleared.
- Reset: state=IDLE; all valid bits 0; counters 0. Outputs: cpu_ack=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, flushing=0, cpu_ready=1 (when flush=0).
- Reset mid-FILL/WRITE drops mem_req immediately and abandons the transfer; a later mem_ack is ignored.
- Reset mid-FLUSH leaves all lines invalid, because reset clears every valid bit.

## Timing
- Request accepted at edge N (cpu_req and cpu_ready high).
- Read hit: LOOKUP during N+1, cpu_ack during N+2 (2-cycle latency).
- Miss or write: mem_req rises in cycle N+2. If mem_ack is sampled at edge M, cpu_ack is high during M+1 and mem_req is low in M+1.
- Zero-wait memory (mem_ack high in the first mem_req cycle): cpu_ack 3 cycles after acceptance.
- cpu_ready is low from N+1 through the RESP cycle and returns high in the cycle after cpu_ack. Back-to-back requests therefore have a minimum spacing of 3 cycles.
- Data/tag arrays may be registers or distributed RAM but must be readable combinationally in LOOKUP.

## Test plan
- Reset, then read 0x0013 with mem_rdata=0xA5 and mem_ack after 2 cycles:
  - one FILL, mem_addr=0x0013, cpu_rdata=0xA5 with cpu_ack
  - miss_count=1
- Repeat read 0x0013: cpu_ack 2 cycles after acceptance, mem_req never rises, cpu_rdata=0xA5, hit_count=1.
- Read 0x0023 (same index 3, different tag), mem returns 0x3C: line replaced; a following read of 0x0013 misses again (miss_count=3).
- Write 0x0023 with 0x77 (hit):
  - mem_we=1, mem_wdata=0x77 until mem_ack
  - a following read of 0x0023 hits with 0x77
  - a write to uncached 0x0045 leaves line 5 invalid
- Assert flush together with cpu_req in IDLE: request not accepted, flushing high exactly 16 cycles, then read 0x0023 misses.
- Drive hit_count past 65535 (force preload or a long loop): it holds at 0xFFFF. Assert rst while mem_req=1 in FILL: mem_req=0 immediately, no cpu_ack, all lines invalid.

Source files
------------

// File: rtl/direct_cache_ctrl_if.sv
// direct_cache_ctrl bus bundle: CPU port, memory port, flush and statistics.
// master = CPU/memory side driver, slave = cache controller.
interface direct_cache_ctrl_if #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 16
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [AddrWidth-1:0] cpu_addr;
  logic [DataWidth-1:0] cpu_wdata;
  logic                 cpu_ready;
  logic                 cpu_ack;
  logic [DataWidth-1:0] cpu_rdata;
  logic                 mem_req;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_rdata;
  logic                 mem_ack;
  logic                 flush;
  logic                 flushing;
  logic [15:0]          hit_count;
  logic [15:0]          miss_count;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata, mem_ack, flush,
    input  cpu_ready, cpu_ack, cpu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  flushing, hit_count, miss_count
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata, mem_ack, flush,
    output cpu_ready, cpu_ack, cpu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output flushing, hit_count, miss_count
  );
endinterface

// File: rtl/direct_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller
// with sequenced flush and saturating hit/miss statistics.
module direct_cache_ctrl #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 16,
  parameter int IndexBits = 4
) (
  input  logic               clk,
  input  logic               rst,
  direct_cache_ctrl_if.slave bus
);
  localparam int Lines   = 1 << IndexBits;
  localparam int TagBits = AddrWidth - IndexBits;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RESP, S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic                 we_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] rdata_q;
  logic [15:0]          hcnt_q;
  logic [15:0]          mcnt_q;
  logic [Lines-1:0]     valid_q;
  logic [IndexBits-1:0] fcnt_q;

  logic [TagBits-1:0]   tag_mem  [Lines];
  logic [DataWidth-1:0] data_mem [Lines];

  logic [IndexBits-1:0] idx;
  logic [TagBits-1:0]   tag;
  logic                 hit;
  logic                 accept;
  logic                 fill_done;
  logic                 write_done;

  assign idx = addr_q[IndexBits-1:0];
  assign tag = addr_q[AddrWidth-1:IndexBits];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  assign accept     = (state_q == S_IDLE) && !bus.flush && bus.cpu_req;
  assign fill_done  = (state_q == S_FILL) && bus.mem_ack;
  assign write_done = (state_q == S_WRITE) && bus.mem_ack;

  assign bus.cpu_ready  = (state_q == S_IDLE) && !bus.flush;
  assign bus.cpu_ack    = (state_q == S_RESP);
  assign bus.cpu_rdata  = rdata_q;
  assign bus.mem_req    = (state_q == S_FILL) || (state_q == S_WRITE);
  assign bus.mem_we     = (state_q == S_WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.flushing   = (state_q == S_FLUSH);
  assign bus.hit_count  = hcnt_q;
  assign bus.miss_count = mcnt_q;

  // Next-state logic; flush wins over a simultaneous request in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.flush)        state_d = S_FLUSH;
        else if (bus.cpu_req) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (we_q)     state_d = S_WRITE;
        else if (hit) state_d = S_RESP;
        else          state_d = S_FILL;
      end
      S_FILL:  if (bus.mem_ack) state_d = S_RESP;
      S_WRITE: if (bus.mem_ack) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_FLUSH: if (&fcnt_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request register, loaded on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.cpu_we;
      addr_q  <= bus.cpu_addr;
      wdata_q <= bus.cpu_wdata;
    end
  end

  // Read data returned to the CPU, held until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == S_LOOKUP && !we_q && hit) begin
      rdata_q <= data_mem[idx];
    end else if (fill_done) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  // Saturating statistics, one bump per lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      mcnt_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) begin
        if (hcnt_q != 16'hFFFF) hcnt_q <= hcnt_q + 16'd1;
      end else begin
        if (mcnt_q != 16'hFFFF) mcnt_q <= mcnt_q + 16'd1;
      end
    end
  end

  // Valid bits: set by fills, cleared line-by-line by the flush walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      fcnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && bus.flush) fcnt_q <= '0;
      if (state_q == S_FLUSH) begin
        valid_q[fcnt_q] <= 1'b0;
        fcnt_q          <= fcnt_q + IndexBits'(1);
      end
      if (fill_done) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays; contents are qualified by valid, so no reset.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx] <= bus.mem_rdata;
      tag_mem[idx]  <= tag;
    end else if (write_done && hit) begin
      data_mem[idx] <= wdata_q;
    end
  end
endmodule
